// File: rtl/edge_generator.sv
// edge_generator: rebuilds glitch-free output levels from per-channel edge request pulses,
// holding each level for at least min_cycles+1 cycles. Define EDGE_GEN_PENDING_EN for a one-deep pend slot.
module edge_generator #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] pos_req,
  input  logic [WIDTH-1:0] neg_req,
  input  logic [CNT_W-1:0] min_cycles,
  output logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] drop
);

`ifdef EDGE_GEN_PENDING_EN
  localparam logic PEND_EN = 1'b1;
`else
  localparam logic PEND_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE_LO   = 3'd0,
    IDLE_HI   = 3'd1,
    HOLD      = 3'd2,
    HOLD_PEND = 3'd3,
    APPLY     = 3'd4
  } ch_state_e;

  typedef struct packed {
    logic             sig;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             drop;
  } ch_t;

  function automatic ch_state_e state_of(input ch_t c);
    ch_state_e st;
    if (c.cnt != CNT_ZERO) begin
      st = c.pend ? HOLD_PEND : HOLD;
    end else if (c.pend) begin
      st = APPLY;
    end else begin
      st = c.sig ? IDLE_HI : IDLE_LO;
    end
    return st;
  endfunction

  // A single request targets level p; a pulse is p&n. With a pend set, eff = ~sig.
  function automatic ch_t step(input ch_t cur, input logic p, input logic n,
                               input logic [CNT_W-1:0] m);
    ch_t  nxt;
    logic pulse;
    logic single;
    nxt      = cur;
    nxt.drop = 1'b0;
    pulse    = p & n;
    single   = p ^ n;
    case (state_of(cur))
      IDLE_LO, IDLE_HI: begin
        if (pulse) begin
          nxt.sig  = ~cur.sig;
          nxt.cnt  = m;
          nxt.pend = PEND_EN;
          nxt.drop = ~PEND_EN;
        end else if (single && (p != cur.sig)) begin
          nxt.sig = ~cur.sig;
          nxt.cnt = m;
        end else begin
          nxt.drop = 1'b0;
        end
      end
      APPLY: begin
        // Queued flip lands now; a same-cycle request is judged against the new level ~sig.
        nxt.sig  = ~cur.sig;
        nxt.cnt  = m;
        nxt.pend = 1'b0;
        if (pulse) begin
          nxt.pend = PEND_EN;
          nxt.drop = 1'b1;
        end else if (single && (p == cur.sig)) begin
          nxt.pend = PEND_EN;
          nxt.drop = ~PEND_EN;
        end else begin
          nxt.drop = 1'b0;
        end
      end
      HOLD: begin
        nxt.cnt = cur.cnt - CNT_ONE;
        if (pulse) begin
          nxt.pend = PEND_EN;
          nxt.drop = 1'b1;
        end else if (single && (p != cur.sig)) begin
          nxt.pend = PEND_EN;
          nxt.drop = ~PEND_EN;
        end else begin
          nxt.drop = 1'b0;
        end
      end
      HOLD_PEND: begin
        nxt.cnt = cur.cnt - CNT_ONE;
        if (pulse || (single && (p == cur.sig))) begin
          nxt.drop = 1'b1;
        end else begin
          nxt.drop = 1'b0;
        end
      end
      default: begin
        nxt      = cur;
        nxt.drop = 1'b0;
      end
    endcase
    return nxt;
  endfunction

  logic [WIDTH-1:0] sig_r;
  logic [WIDTH-1:0] pend_r;
  logic [WIDTH-1:0] busy_r;
  logic [WIDTH-1:0] drop_r;
  logic [CNT_W-1:0] cnt_r [WIDTH];
  logic [WIDTH-1:0] sig_s;
  logic [WIDTH-1:0] pend_s;
  logic [WIDTH-1:0] busy_s;
  logic [WIDTH-1:0] drop_s;
  logic [CNT_W-1:0] cnt_s [WIDTH];

  // Next state for every channel from its registers and this cycle's requests.
  always_comb begin
    ch_t cur;
    ch_t nxt;
    cur    = '0;
    nxt    = '0;
    sig_s  = {WIDTH{1'b0}};
    pend_s = {WIDTH{1'b0}};
    busy_s = {WIDTH{1'b0}};
    drop_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_s[i] = CNT_ZERO;
    end
    for (int i = 0; i < WIDTH; i++) begin
      cur.sig   = sig_r[i];
      cur.cnt   = cnt_r[i];
      cur.pend  = pend_r[i];
      cur.drop  = 1'b0;
      nxt       = step(cur, pos_req[i], neg_req[i], min_cycles);
      sig_s[i]  = nxt.sig;
      cnt_s[i]  = nxt.cnt;
      pend_s[i] = nxt.pend;
      drop_s[i] = nxt.drop;
      busy_s[i] = (nxt.cnt != CNT_ZERO) || nxt.pend;
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sig_r  <= {WIDTH{1'b0}};
      pend_r <= {WIDTH{1'b0}};
      busy_r <= {WIDTH{1'b0}};
      drop_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sig_r  <= sig_s;
      pend_r <= pend_s;
      busy_r <= busy_s;
      drop_r <= drop_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  assign signal = sig_r;
  assign busy   = busy_r;
  assign drop   = drop_r;

endmodule

// File: tb/tb_edge_generator.sv
// tb_edge_generator: vector table with a scoreboard queue for edge_generator (WIDTH=4),
// plus a hand-written asynchronous reset sequence. Expectations track EDGE_GEN_PENDING_EN.
module tb_edge_generator;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [WIDTH-1:0] pos_req;
  logic [WIDTH-1:0] neg_req;
  logic [CNT_W-1:0] min_cycles;
  logic [WIDTH-1:0] signal;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] drop;

  edge_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pos_req    (pos_req),
    .neg_req    (neg_req),
    .min_cycles (min_cycles),
    .signal     (signal),
    .busy       (busy),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  // exp nibbles: {signal, busy, drop} after the edge that consumes the vector
  typedef struct {
    logic [3:0]  pos;
    logic [3:0]  neg;
    logic [7:0]  m;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic add(input logic [3:0] p, input logic [3:0] n, input logic [7:0] m,
                     input logic [11:0] exp_nopend, input logic [11:0] exp_pend);
    vec_t v;
    v.pos = p;
    v.neg = n;
    v.m   = m;
`ifdef EDGE_GEN_PENDING_EN
    v.exp = exp_pend;
`else
    v.exp = exp_nopend;
`endif
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [11:0] e;
    n_rst      = 1'b0;
    pos_req    = 4'b0000;
    neg_req    = 4'b0000;
    min_cycles = 8'd0;
    #12;
    check("rst_signal", -1, signal, 4'b0000);
    check("rst_busy",   -1, busy,   4'b0000);
    check("rst_drop",   -1, drop,   4'b0000);
    @(negedge clk);
    n_rst = 1'b1;

    // M=0: single-cycle flips, redundant request ignored
    add(4'h0, 4'h0, 8'd0, 12'h000, 12'h000);
    add(4'h0, 4'h0, 8'd0, 12'h000, 12'h000);
    add(4'h0, 4'h0, 8'd0, 12'h000, 12'h000);
    add(4'h1, 4'h0, 8'd0, 12'h100, 12'h100);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);
    add(4'h1, 4'h0, 8'd0, 12'h100, 12'h100);
    add(4'h1, 4'h0, 8'd0, 12'h100, 12'h100);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);
    // M=4: pos then neg during hold
    add(4'h1, 4'h0, 8'd4, 12'h110, 12'h110);
    add(4'h0, 4'h1, 8'd4, 12'h111, 12'h110);
    add(4'h0, 4'h0, 8'd4, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd4, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h110);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h000);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);
    // M=4: pos, neg, pos -> slot full
    add(4'h1, 4'h0, 8'd4, 12'h110, 12'h110);
    add(4'h0, 4'h1, 8'd4, 12'h111, 12'h110);
    add(4'h1, 4'h0, 8'd4, 12'h110, 12'h111);
    add(4'h0, 4'h0, 8'd4, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h110);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd4, 12'h100, 12'h000);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);
    // M=2: simultaneous pos+neg from idle low
    add(4'h1, 4'h1, 8'd2, 12'h111, 12'h110);
    add(4'h0, 4'h0, 8'd2, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd2, 12'h100, 12'h110);
    add(4'h0, 4'h0, 8'd2, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd2, 12'h100, 12'h010);
    add(4'h0, 4'h0, 8'd2, 12'h100, 12'h000);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);
    // M=0 pulse
    add(4'h1, 4'h1, 8'd0, 12'h101, 12'h110);
    add(4'h0, 4'h0, 8'd0, 12'h100, 12'h000);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);
    // multi-channel independence
    add(4'h8, 4'h0, 8'd0, 12'h800, 12'h800);
    add(4'h1, 4'h8, 8'd3, 12'h190, 12'h190);
    add(4'h0, 4'h1, 8'd3, 12'h191, 12'h190);
    add(4'h4, 4'h0, 8'd3, 12'h5D0, 12'h5D0);
    add(4'h0, 4'h0, 8'd3, 12'h540, 12'h550);
    add(4'h0, 4'h0, 8'd3, 12'h540, 12'h450);
    add(4'h0, 4'h0, 8'd3, 12'h500, 12'h410);
    add(4'h0, 4'h0, 8'd3, 12'h500, 12'h410);
    add(4'h0, 4'h0, 8'd3, 12'h500, 12'h400);
    add(4'h0, 4'h5, 8'd0, 12'h000, 12'h000);
    // min_cycles changed mid-hold must not disturb the count
    add(4'h1, 4'h0, 8'd3, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd0, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd0, 12'h110, 12'h110);
    add(4'h0, 4'h0, 8'd0, 12'h100, 12'h100);
    add(4'h0, 4'h1, 8'd0, 12'h000, 12'h000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pos_req    = vecs[i].pos;
      neg_req    = vecs[i].neg;
      min_cycles = vecs[i].m;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("signal", i, signal, e[11:8]);
      check("busy",   i, busy,   e[7:4]);
      check("drop",   i, drop,   e[3:0]);
    end

    // Asynchronous reset in the middle of a long hold
    @(negedge clk);
    pos_req    = 4'b0001;
    neg_req    = 4'b0000;
    min_cycles = 8'd10;
    @(negedge clk);
    pos_req = 4'b0000;
    neg_req = 4'b0001;
    @(posedge clk);
    #3;
    check("hold_signal", -2, signal, 4'b0001);
    check("hold_busy",   -2, busy,   4'b0001);
    n_rst = 1'b0;
    #1;
    check("arst_signal", -2, signal, 4'b0000);
    check("arst_busy",   -2, busy,   4'b0000);
    check("arst_drop",   -2, drop,   4'b0000);
    @(negedge clk);
    neg_req = 4'b0000;
    n_rst   = 1'b1;
    @(negedge clk);
    pos_req    = 4'b0001;
    min_cycles = 8'd0;
    @(posedge clk);
    #1;
    check("post_signal", -3, signal, 4'b0001);
    check("post_busy",   -3, busy,   4'b0000);
    check("post_drop",   -3, drop,   4'b0000);
    @(negedge clk);
    pos_req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
